uart_rx_gen: RTL and testbench
==============================

UART_RX_GEN -- requirements
Module: uart_rx_gen

Interface
REQ-001 SHALL have parameter DBIT, default 8, data bits per frame (5..9).
REQ-002 SHALL have parameter OVS, default 16, baud ticks per bit (even, 8..32).
REQ-003 SHALL have parameter SB_TICK, default 16, ticks in stop interval (16/24/32 = 1/1.5/2 stop bits at OVS=16).
REQ-004 SHALL have parameter DIVISOR, default 651, clk cycles per baud tick (>=2).
REQ-005 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port rx, input, 1, asynchronous serial line, idle high.
REQ-008 SHALL have port parity_odd, input, 1, 1 = odd parity, 0 = even; ignored without UART_RX_PARITY_EN.
REQ-009 SHALL have port rx_done_tick, output, 1, one-cycle pulse per completed frame.
REQ-010 SHALL have port rx_dout, output, DBIT, last received word, LSB first on line.
REQ-011 SHALL have port frame_err, output, 1, stop-bit sample was 0 on last frame.
REQ-012 SHALL have port parity_err, output, 1, parity mismatch on last frame.

Function
REQ-013 Tick generator SHALL count 0..DIVISOR-1, wrap to 0, and pulse tick for one clk when count == DIVISOR-1; free-running, never stalls.
REQ-014 rx SHALL pass through a 2-flop synchroniser before any use; latency 2 clk.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, BRK.
REQ-016 IDLE: synchronised rx == 0 -> START, tick counter s = 0.
REQ-017 START: on tick with s == OVS/2-1, rx == 0 -> DATA (s = 0, n = 0); rx == 1 -> IDLE (false start, no pulse).
REQ-018 DATA: on tick with s == OVS-1, shift rx into MSB of shift register (right shift), s = 0; after bit DBIT-1 -> PARITY if enabled, else STOP.
REQ-019 PARITY: on tick with s == OVS-1, capture parity bit, s = 0 -> STOP.
REQ-020 STOP: on tick with s == SB_TICK-1, sample rx; rx_dout, frame_err (= ~rx), parity_err SHALL load; rx_done_tick = 1 next clk cycle only.
REQ-021 STOP exit SHALL go to IDLE if stop sample is 1, else BRK.
REQ-022 BRK SHALL wait for synchronised rx == 1, then -> IDLE; no rx_done_tick while in BRK.
REQ-023 rx_dout, frame_err and parity_err SHALL hold stable between rx_done_tick pulses.
REQ-024 Counters s and n SHALL be $clog2 sized to max(OVS, SB_TICK) and DBIT, with no overflow at the largest legal parameter values.
REQ-025 The next frame's start edge SHALL be accepted in the clk cycle after STOP exit (back-to-back frames).

Reset
REQ-026 reset_n low SHALL immediately force IDLE, s = n = 0, shift register 0, synchroniser flops 1, tick counter 0, and all outputs 0.
REQ-027 reset mid-frame SHALL discard the partial word; no rx_done_tick is produced for it.

Configuration
REQ-028 Macro UART_RX_PARITY_EN defined: PARITY state is used; parity_err = XOR(data, parity bit, parity_odd) != 0.
REQ-029 UART_RX_PARITY_EN undefined: PARITY state and logic are absent; DATA -> STOP; parity_err tied 0; parity_odd unused.

Structure
REQ-030 Package uart_pkg SHALL hold the FSM state typedef and the parity-mode constants.
REQ-031 Tick generator SHALL be sub-module uart_baud_tick (parameter DIVISOR, ports clk, reset_n, tick).

Verification (DIVISOR=4, OVS=16, SB_TICK=16, DBIT=8)
REQ-032 Send 0xA5 8N1 -> exactly one rx_done_tick, rx_dout = 0xA5, frame_err = 0, parity_err = 0.
REQ-033 Parity enabled, even, send 0x03 with parity bit 1 -> rx_dout = 0x03, parity_err = 1; resend with parity bit 0 -> parity_err = 0.
REQ-034 rx low for 3 ticks, then high -> no rx_done_tick; FSM back in IDLE.
REQ-035 rx low for 20 bit times -> one pulse, rx_dout = 0x00, frame_err = 1; no further pulse until rx high; then 0x55 -> rx_dout = 0x55, frame_err = 0.
REQ-036 reset_n pulsed during bit 4 of 0xFF -> outputs 0, no pulse; next frame 0x3C -> rx_dout = 0x3C.
REQ-037 0x00 and 0xFF with no idle gap -> two pulses, values 0x00 then 0xFF, no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver.
// Optional feature macro: UART_RX_PARITY_EN (adds a parity bit after the data bits).
package uart_pkg;

    // Receiver FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BRK    = 3'd5
    } rx_state_e;

    // Values of the parity_odd input
    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // Larger of two integers, used to size the shared tick counter
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Nonzero when data + parity bit do not match the selected parity mode.
    // Data narrower than 9 bits is zero-extended, which leaves the XOR unchanged.
    function automatic logic parity_mismatch(input logic [8:0] data,
                                             input logic       par_bit,
                                             input logic       odd);
        return ^{data, par_bit, odd};
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running baud tick generator: one-clock tick every DIVISOR clocks.
module uart_baud_tick #(
    parameter int DIVISOR = 651
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: wrap to zero after DIVISOR-1
    always_comb begin
        if (cnt_q == CW'(DIVISOR - 1)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CW'(DIVISOR - 1));

endmodule

// File: rtl/uart_rx_gen.sv
// Oversampling UART receiver with stop-bit framing check and break handling.
// Optional feature macro: UART_RX_PARITY_EN enables a parity bit and parity_err.
module uart_rx_gen
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int OVS     = 16,
    parameter int SB_TICK = 16,
    parameter int DIVISOR = 651
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            rx,
    input  logic            parity_odd,
    output logic            rx_done_tick,
    output logic [DBIT-1:0] rx_dout,
    output logic            frame_err,
    output logic            parity_err
);

    localparam int S_W = $clog2(max_int(OVS, SB_TICK));
    localparam int N_W = $clog2(DBIT);

    logic            tick_s;
    logic            rx_s;
    logic            stop_hit_s;
    logic            sync1_q, sync2_q;
    rx_state_e       state_q, state_d;
    logic [S_W-1:0]  s_q, s_d;
    logic [N_W-1:0]  n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            ferr_q, ferr_d;
    logic            perr_q, perr_d;
    logic            done_q, done_d;
`ifdef UART_RX_PARITY_EN
    logic            par_q, par_d;
`else
    logic            unused_parity_odd_s;
    assign unused_parity_odd_s = parity_odd;
`endif

    uart_baud_tick #(.DIVISOR(DIVISOR)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick_s)
    );

    assign rx_s       = sync2_q;
    assign stop_hit_s = (state_q == ST_STOP) && tick_s && (s_q == S_W'(SB_TICK - 1));

    // State, datapath, synchroniser and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= ST_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            dout_q  <= '0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            dout_q  <= dout_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
            done_q  <= done_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state and bit-timing logic; counters advance only on baud ticks
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    s_d     = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    if (s_q == S_W'(OVS / 2 - 1)) begin
                        s_d = '0;
                        if (!rx_s) begin
                            state_d = ST_DATA;
                            n_d     = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end else begin
                    s_d = s_q;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    if (s_q == S_W'(OVS - 1)) begin
                        s_d = '0;
                        b_d = {rx_s, b_q[DBIT-1:1]};
                        if (n_q == N_W'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            n_d = n_q + N_W'(1);
                        end
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end else begin
                    s_d = s_q;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick_s) begin
                    if (s_q == S_W'(OVS - 1)) begin
                        s_d     = '0;
                        par_d   = rx_s;
                        state_d = ST_STOP;
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end else begin
                    s_d = s_q;
                end
            end
`endif
            ST_STOP: begin
                if (tick_s) begin
                    if (s_q == S_W'(SB_TICK - 1)) begin
                        s_d     = '0;
                        state_d = rx_s ? ST_IDLE : ST_BRK;
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end else begin
                    s_d = s_q;
                end
            end
            ST_BRK: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BRK;
                end
            end
            default: begin
                state_d = ST_IDLE;
                s_d     = '0;
                n_d     = '0;
            end
        endcase
    end

    // Result capture at the stop-bit sample; pulse appears the following cycle
    always_comb begin
        done_d = 1'b0;
        dout_d = dout_q;
        ferr_d = ferr_q;
        perr_d = perr_q;
        if (stop_hit_s) begin
            done_d = 1'b1;
            dout_d = b_q;
            ferr_d = ~rx_s;
`ifdef UART_RX_PARITY_EN
            perr_d = parity_mismatch(9'(b_q), par_q, parity_odd);
`else
            perr_d = 1'b0;
`endif
        end else begin
            done_d = 1'b0;
        end
    end

    assign rx_done_tick = done_q;
    assign rx_dout      = dout_q;
    assign frame_err    = ferr_q;
    assign parity_err   = perr_q;

endmodule

// File: tb/tb_uart_rx_gen.sv
// Directed self-checking bench for uart_rx_gen (DIVISOR=4, OVS=16, 8 data bits).
module tb_uart_rx_gen;

    localparam int DIVISOR = 4;
    localparam int OVS     = 16;
    localparam int SB_TICK = 16;
    localparam int DBIT    = 8;
    localparam int BIT_CLK = OVS * DIVISOR;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            rx;
    logic            parity_odd;
    logic            rx_done_tick;
    logic [DBIT-1:0] rx_dout;
    logic            frame_err;
    logic            parity_err;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int p0;
    logic [7:0] cap_dout[$];
    logic [1:0] cap_err[$];

    uart_rx_gen #(
        .DBIT    (DBIT),
        .OVS     (OVS),
        .SB_TICK (SB_TICK),
        .DIVISOR (DIVISOR)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx           (rx),
        .parity_odd   (parity_odd),
        .rx_done_tick (rx_done_tick),
        .rx_dout      (rx_dout),
        .frame_err    (frame_err),
        .parity_err   (parity_err)
    );

    always #5 clk = ~clk;

    // Count done pulses and capture the word delivered with each one
    always @(negedge clk) begin
        if (rx_done_tick === 1'b1) begin
            pulses = pulses + 1;
            cap_dout.push_back(rx_dout);
            cap_err.push_back({frame_err, parity_err});
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hold the line at level v for n bit times (aligned to falling edges)
    task automatic hold_bits(input logic v, input int n);
        rx = v;
        repeat (n * BIT_CLK) @(negedge clk);
    endtask

    // One frame: start, data LSB first, optional parity, one stop bit
    task automatic send_frame_par(input logic [7:0] d, input logic p);
        hold_bits(1'b0, 1);
        for (int i = 0; i < 8; i++) begin
            hold_bits(d[i], 1);
        end
`ifdef UART_RX_PARITY_EN
        hold_bits(p, 1);
`else
        if (p === 1'bx) begin
            hold_bits(1'b1, 0);
        end else begin
            hold_bits(1'b1, 0);
        end
`endif
        hold_bits(1'b1, 1);
    endtask

    // Frame with correct even parity
    task automatic send_frame(input logic [7:0] d);
        send_frame_par(d, ^d);
    endtask

    initial begin
        rx         = 1'b1;
        parity_odd = 1'b0;
        reset_n    = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_done", {15'd0, rx_done_tick}, 16'd0);
        check("reset_dout", {8'd0, rx_dout}, 16'd0);
        check("reset_ferr", {15'd0, frame_err}, 16'd0);
        check("reset_perr", {15'd0, parity_err}, 16'd0);
        reset_n = 1'b1;
        hold_bits(1'b1, 2);
        check("idle_no_pulse", pulses[15:0], 16'd0);

        // Plain frame 0xA5
        p0 = pulses;
        send_frame(8'hA5);
        hold_bits(1'b1, 1);
        check("a5_pulses", 16'(pulses - p0), 16'd1);
        check("a5_dout", {8'd0, rx_dout}, 16'h00A5);
        check("a5_ferr", {15'd0, frame_err}, 16'd0);
        check("a5_perr", {15'd0, parity_err}, 16'd0);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x03 has two ones, so parity bit 1 is wrong, 0 is right
        send_frame_par(8'h03, 1'b1);
        hold_bits(1'b1, 1);
        check("par1_dout", {8'd0, rx_dout}, 16'h0003);
        check("par1_perr", {15'd0, parity_err}, 16'd1);
        send_frame_par(8'h03, 1'b0);
        hold_bits(1'b1, 1);
        check("par0_dout", {8'd0, rx_dout}, 16'h0003);
        check("par0_perr", {15'd0, parity_err}, 16'd0);
`endif

        // False start: 3 ticks low then high
        p0 = pulses;
        rx = 1'b0;
        repeat (3 * DIVISOR) @(negedge clk);
        hold_bits(1'b1, 3);
        check("false_start_pulses", 16'(pulses - p0), 16'd0);
        send_frame(8'h5A);
        hold_bits(1'b1, 1);
        check("after_false_dout", {8'd0, rx_dout}, 16'h005A);
        check("after_false_pulses", 16'(pulses - p0), 16'd1);

        // Break: line low for 20 bit times
        p0 = pulses;
        hold_bits(1'b0, 20);
        check("brk_pulses", 16'(pulses - p0), 16'd1);
        check("brk_dout", {8'd0, rx_dout}, 16'h0000);
        check("brk_ferr", {15'd0, frame_err}, 16'd1);
        check("brk_perr", {15'd0, parity_err}, 16'd0);
        hold_bits(1'b1, 2);
        check("brk_release_pulses", 16'(pulses - p0), 16'd1);
        send_frame(8'h55);
        hold_bits(1'b1, 1);
        check("post_brk_dout", {8'd0, rx_dout}, 16'h0055);
        check("post_brk_ferr", {15'd0, frame_err}, 16'd0);
        check("post_brk_pulses", 16'(pulses - p0), 16'd2);

        // Reset during bit 4 of 0xFF
        p0 = pulses;
        hold_bits(1'b0, 1);
        hold_bits(1'b1, 4);
        rx = 1'b1;
        repeat (BIT_CLK / 4) @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid_dout", {8'd0, rx_dout}, 16'd0);
        check("rst_mid_ferr", {15'd0, frame_err}, 16'd0);
        check("rst_mid_done", {15'd0, rx_done_tick}, 16'd0);
        reset_n = 1'b1;
        hold_bits(1'b1, 12);
        check("rst_mid_pulses", 16'(pulses - p0), 16'd0);
        check("rst_mid_dout_hold", {8'd0, rx_dout}, 16'd0);
        send_frame(8'h3C);
        hold_bits(1'b1, 1);
        check("after_rst_dout", {8'd0, rx_dout}, 16'h003C);
        check("after_rst_pulses", 16'(pulses - p0), 16'd1);

        // Back-to-back 0x00 then 0xFF with no idle gap
        cap_dout.delete();
        cap_err.delete();
        p0 = pulses;
        send_frame(8'h00);
        send_frame(8'hFF);
        hold_bits(1'b1, 1);
        check("b2b_pulses", 16'(pulses - p0), 16'd2);
        check("b2b_first", {8'd0, cap_dout[0]}, 16'h0000);
        check("b2b_second", {8'd0, cap_dout[1]}, 16'h00FF);
        check("b2b_err0", {14'd0, cap_err[0]}, 16'd0);
        check("b2b_err1", {14'd0, cap_err[1]}, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
